// File: rtl/nn_resample_ctrl.sv
// nn_resample_ctrl: nearest-neighbour pitch-shift frame sequencer.
// Walks output index 0..511 and computes the source address index*shift
// (unsigned fixed point). It reads the source BRAM and writes the
// destination buffer. Addresses past src_len or past the source address
// range give a zero sample.
// Build option: define NN_ROUND_EN to round the source address half-up
// instead of truncating it.
//
// state    | meaning
// ---------+-------------------------------------------------------
// ST_IDLE  | waiting for start, outputs quiet
// ST_RUN   | issuing output indices 0..511, one per cycle
// ST_DRAIN | letting the 3-stage pipeline empty, then pulse done
module nn_resample_ctrl #(
  parameter int FRAME_LOG2 = 9,
  parameter int SRC_AW     = 11,
  parameter int SHIFT_W    = 32,
  parameter int FRAC_BITS  = 20,
  parameter int DATA_W     = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [SHIFT_W-1:0]    shift,
  input  logic [SRC_AW-1:0]     src_len,
  output logic                  busy,
  output logic                  done,
  output logic [SRC_AW-1:0]     src_addr,
  input  logic [DATA_W-1:0]     src_data,
  output logic [FRAME_LOG2-1:0] dst_addr,
  output logic [DATA_W-1:0]     dst_data,
  output logic                  dst_we
);

  localparam int PROD_W = FRAME_LOG2 + SHIFT_W;
  localparam int SUM_W  = PROD_W + 1;
  localparam logic [SUM_W-1:0] A_MAX = SUM_W'((2 ** SRC_AW) - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  state_t                state_q, state_d;
  logic [FRAME_LOG2-1:0] idx_q, idx_d;
  logic [1:0]            drain_q, drain_d;
  logic [SHIFT_W-1:0]    shift_q, shift_d;
  logic [SRC_AW-1:0]     len_q, len_d;
  logic                  done_q, done_d;

  logic                  a_vld_q, a_vld_d;
  logic                  a_oob_q, a_oob_d;
  logic [FRAME_LOG2-1:0] a_idx_q, a_idx_d;
  logic [SRC_AW-1:0]     src_addr_q, src_addr_d;

  logic                  b_vld_q, b_vld_d;
  logic                  b_oob_q, b_oob_d;
  logic [FRAME_LOG2-1:0] b_idx_q, b_idx_d;

  logic                  dst_we_q, dst_we_d;
  logic [FRAME_LOG2-1:0] dst_addr_q, dst_addr_d;
  logic [DATA_W-1:0]     dst_data_q, dst_data_d;

  logic [PROD_W-1:0]     prod;
  logic [SUM_W-1:0]      sum;
  logic [SUM_W-1:0]      a_full;
  logic                  oob;

  // Sequencer next state: latch config on start, count indices, drain pipeline.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    drain_d = drain_q;
    shift_d = shift_q;
    len_d   = len_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          shift_d = shift;
          len_d   = src_len;
          idx_d   = '0;
        end
      end
      ST_RUN: begin
        if (idx_q == {FRAME_LOG2{1'b1}}) begin
          state_d = ST_DRAIN;
          drain_d = 2'd2;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_q == 2'd0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Address datapath and pipeline stage next values.
  always_comb begin
    prod = PROD_W'(idx_q) * PROD_W'(shift_q);
`ifdef NN_ROUND_EN
    sum  = SUM_W'(prod) + (SUM_W'(1) << (FRAC_BITS - 1));
`else
    sum  = SUM_W'(prod);
`endif
    a_full = sum >> FRAC_BITS;
    oob    = (a_full >= SUM_W'(len_q)) || (a_full > A_MAX);

    a_vld_d    = (state_q == ST_RUN);
    a_idx_d    = idx_q;
    a_oob_d    = oob;
    src_addr_d = (a_vld_d && !oob) ? a_full[SRC_AW-1:0] : '0;

    b_vld_d = a_vld_q;
    b_oob_d = a_oob_q;
    b_idx_d = a_idx_q;

    dst_we_d   = b_vld_q;
    dst_addr_d = dst_addr_q;
    dst_data_d = dst_data_q;
    if (b_vld_q) begin
      dst_addr_d = b_idx_q;
      dst_data_d = b_oob_q ? '0 : src_data;
    end
  end

  // All state and pipeline registers; reset abandons any frame in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      drain_q    <= '0;
      shift_q    <= '0;
      len_q      <= '0;
      done_q     <= 1'b0;
      a_vld_q    <= 1'b0;
      a_oob_q    <= 1'b0;
      a_idx_q    <= '0;
      src_addr_q <= '0;
      b_vld_q    <= 1'b0;
      b_oob_q    <= 1'b0;
      b_idx_q    <= '0;
      dst_we_q   <= 1'b0;
      dst_addr_q <= '0;
      dst_data_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      drain_q    <= drain_d;
      shift_q    <= shift_d;
      len_q      <= len_d;
      done_q     <= done_d;
      a_vld_q    <= a_vld_d;
      a_oob_q    <= a_oob_d;
      a_idx_q    <= a_idx_d;
      src_addr_q <= src_addr_d;
      b_vld_q    <= b_vld_d;
      b_oob_q    <= b_oob_d;
      b_idx_q    <= b_idx_d;
      dst_we_q   <= dst_we_d;
      dst_addr_q <= dst_addr_d;
      dst_data_q <= dst_data_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign src_addr = src_addr_q;
  assign dst_addr = dst_addr_q;
  assign dst_data = dst_data_q;
  assign dst_we   = dst_we_q;

endmodule
